// File: rtl/load_run_ctrl_pkg.sv
// rtl/load_run_ctrl_pkg.sv - shared state encodings and defaults for the SAP load/run controller
package load_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  localparam int MEM_DEPTH_DEF = 16;

endpackage

// File: rtl/load_run_ctrl_rise_detect.sv
// rtl/load_run_ctrl_rise_detect.sv - registered rising-edge detector for the step request
module rise_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_in,
  output logic o_pulse
);

  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_in;
    end
  end

  assign o_pulse = i_in & ~r_prev;

endmodule

// File: rtl/load_run_ctrl.sv
// rtl/load_run_ctrl.sv - arbitrates SAP RAM between loader and CPU, sequences run/step, counts cycles
import load_run_ctrl_pkg::*;

module load_run_ctrl #(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ADR_W     = 4,
  parameter int CYC_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load_req,
  input  logic             i_run_req,
  input  logic             i_step_req,
  input  logic             i_ld_valid,
  input  logic [7:0]       i_ld_data,
  output logic             o_ld_ready,
  input  logic             i_cpu_halted,
  output logic             o_cpu_en,
  output logic             o_cpu_reset,
  output logic             o_mem_sel,
  output logic             o_mem_we,
  output logic [ADR_W-1:0] o_mem_adr,
  output logic [7:0]       o_mem_data,
  output logic [1:0]       o_state,
  output logic             o_load_done,
  output logic [CYC_W-1:0] o_run_cycles
);

  state_t             r_state;
  state_t             w_next_state;
  logic [ADR_W-1:0]   r_wcnt;
  logic               r_step;
  logic               r_cpu_reset;
  logic               r_load_done;
  logic [CYC_W-1:0]   r_run_cycles;

  logic               w_step_pulse;
  logic               w_hs;
  logic               w_last;
  logic               w_step_nxt;
  logic               w_rst_nxt;
  logic               w_loading;

  rise_detect u_step_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_in    (i_step_req),
    .o_pulse (w_step_pulse)
  );

  always_comb begin
    w_next_state = r_state;
    w_hs         = 1'b0;
    w_last       = 1'b0;
    w_step_nxt   = 1'b0;
    w_rst_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_load_req)        w_next_state = ST_LOAD;
        else if (i_run_req)    w_next_state = ST_RUN;
        else if (w_step_pulse) w_step_nxt   = 1'b1;
      end
      ST_LOAD: begin
        w_hs = i_ld_valid;
        if (w_hs && r_wcnt == ADR_W'(MEM_DEPTH - 1)) begin
          w_last       = 1'b1;
          w_rst_nxt    = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_cpu_halted) w_next_state = ST_HALT;
      end
      ST_HALT: begin
        // Resuming from HALT restarts the program; resuming from IDLE does not.
        if (i_load_req) begin
          w_next_state = ST_LOAD;
        end else if (i_run_req) begin
          w_next_state = ST_RUN;
          w_rst_nxt    = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_wcnt       <= '0;
      r_step       <= 1'b0;
      r_cpu_reset  <= 1'b0;
      r_load_done  <= 1'b0;
      r_run_cycles <= '0;
    end else begin
      r_state     <= w_next_state;
      r_step      <= w_step_nxt;
      r_cpu_reset <= w_rst_nxt;
      r_load_done <= w_last;
      if (w_last)    r_wcnt <= '0;
      else if (w_hs) r_wcnt <= r_wcnt + 1'b1;
      if (w_rst_nxt)                     r_run_cycles <= '0;
      else if (o_cpu_en && ~&r_run_cycles) r_run_cycles <= r_run_cycles + 1'b1;
    end
  end

  assign w_loading    = (r_state == ST_LOAD);
  assign o_ld_ready   = w_loading;
  assign o_mem_sel    = w_loading;
  assign o_mem_we     = w_loading & i_ld_valid;
  assign o_mem_adr    = w_loading ? r_wcnt : '0;
  assign o_mem_data   = w_loading ? i_ld_data : 8'h00;
  assign o_cpu_en     = ((r_state == ST_RUN) & ~r_cpu_reset) | r_step;
  assign o_cpu_reset  = r_cpu_reset;
  assign o_load_done  = r_load_done;
  assign o_state      = r_state;
  assign o_run_cycles = r_run_cycles;

endmodule
